hcsr04_ranger: RTL and testbench

Parametrised HC-SR04 ultrasonic ranging controller. Generates the 10 µs trigger pulse and measures the echo pulse width. Converts the width to centimetres without a divider and flags echoes that never arrive or never end. Runs either free-running at a fixed period or one-shot on request, and feeds the distance value to the game/paddle logic and the 9-bit LED bar.

---
 rtl/hcsr04_ranger.sv | 132 +++++++++++++
 tb/tb_hcsr04_ranger.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/hcsr04_ranger.sv
// HC-SR04 ultrasonic ranging controller: issues the trigger pulse, times the echo
// with a divider-free centimetre prescaler, and flags echoes that never arrive or never end.
module hcsr04_ranger #(
  parameter int CLK_FREQ_HZ = 100_000_000,
  parameter int TRIG_US     = 10,
  parameter int TIMEOUT_US  = 30_000,
  parameter int PERIOD_MS   = 60,
  parameter int CM_US       = 58,
  parameter int DIST_W      = 9,
  parameter bit CONTINUOUS  = 1'b1
) (
  input  logic              clk,
  input  logic              btnC,
  input  logic              enable,
  input  logic              start,
  input  logic              echo,
  output logic              trig,
  output logic [DIST_W-1:0] dist_cm,
  output logic              valid,
  output logic              timeout,
  output logic              busy
);

  localparam int CYC_US      = CLK_FREQ_HZ / 1_000_000;
  localparam int TRIG_CYC    = TRIG_US * CYC_US;
  localparam int TIMEOUT_CYC = TIMEOUT_US * CYC_US;
  localparam int PERIOD_CYC  = PERIOD_MS * 1000 * CYC_US;
  localparam int CM_CYC      = CM_US * CYC_US;

  localparam int TRIG_W = $clog2(TRIG_CYC + 1);
  localparam int TMO_W  = $clog2(TIMEOUT_CYC + 1);
  localparam int PER_W  = $clog2(PERIOD_CYC);
  localparam int PRE_W  = $clog2(CM_CYC + 1);

  localparam logic [TRIG_W-1:0] TRIG_LAST   = TRIG_W'(TRIG_CYC - 1);
  localparam logic [TMO_W-1:0]  TMO_LAST    = TMO_W'(TIMEOUT_CYC - 1);
  localparam logic [PER_W-1:0]  PERIOD_EXIT = PER_W'(PERIOD_CYC - 2);
  localparam logic [PRE_W-1:0]  PRE_LAST    = PRE_W'(CM_CYC - 1);
  localparam logic [DIST_W-1:0] ACC_MAX     = '1;

  typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;

  state_t              state, state_n;
  logic                echo_meta, echo_s, echo_prev;
  logic                echo_rise, echo_fall;
  logic [TRIG_W-1:0]   trig_cnt;
  logic [TMO_W-1:0]    tmo_cnt;
  logic [PER_W-1:0]    period_cnt;
  logic [PRE_W-1:0]    presc;
  logic [DIST_W-1:0]   acc, acc_inc;
  logic                tmo_hit, presc_wrap;
  logic                trig_n, valid_n, timeout_n;

  assign echo_rise  = echo_s & ~echo_prev;
  assign echo_fall  = ~echo_s & echo_prev;
  assign tmo_hit    = (tmo_cnt >= TMO_LAST);
  assign presc_wrap = (presc == PRE_LAST);
  assign acc_inc    = (presc_wrap && acc != ACC_MAX) ? acc + 1'b1 : acc;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (btnC) state <= IDLE;
    else      state <= state_n;
  end

  // NOTE: state_n gets a default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:      if ((CONTINUOUS && enable) || (!CONTINUOUS && start)) state_n = TRIG;
      TRIG:      if (trig_cnt == TRIG_LAST) state_n = WAIT_RISE;
      WAIT_RISE: if (echo_rise) state_n = MEASURE;
                 else if (tmo_hit) state_n = HOLDOFF;
      MEASURE:   if (echo_fall || tmo_hit) state_n = HOLDOFF;
      HOLDOFF:   if (period_cnt >= PERIOD_EXIT) state_n = IDLE;
      default:   state_n = IDLE;
    endcase
  end

  // An echo edge in the same cycle as the timeout takes precedence over it.
  always_comb begin
    busy      = (state != IDLE);
    trig_n    = (state_n == TRIG);
    valid_n   = (state == MEASURE) && echo_fall;
    timeout_n = tmo_hit && (((state == WAIT_RISE) && !echo_rise) ||
                            ((state == MEASURE) && !echo_fall));
  end

  always_ff @(posedge clk) begin
    if (btnC) begin
      echo_meta  <= 1'b0;
      echo_s     <= 1'b0;
      echo_prev  <= 1'b0;
      trig       <= 1'b0;
      valid      <= 1'b0;
      timeout    <= 1'b0;
      dist_cm    <= '0;
      trig_cnt   <= '0;
      tmo_cnt    <= '0;
      period_cnt <= '0;
      presc      <= '0;
      acc        <= '0;
    end else begin
      echo_meta <= echo;
      echo_s    <= echo_meta;
      echo_prev <= echo_s;
      trig      <= trig_n;
      valid     <= valid_n;
      timeout   <= timeout_n;

      trig_cnt <= (state == TRIG && state_n == TRIG) ? trig_cnt + 1'b1 : '0;

      if (state == TRIG)                              tmo_cnt <= '0;
      else if ((state == WAIT_RISE || state == MEASURE) && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;

      if (state == IDLE && state_n == TRIG) period_cnt <= '0;
      else if (state != IDLE)               period_cnt <= period_cnt + 1'b1;

      // The fall cycle stands in for the rise cycle, so the count spans the full echo width.
      if (state == WAIT_RISE) begin
        presc <= '0;
        acc   <= '0;
      end else if (state == MEASURE) begin
        presc <= presc_wrap ? '0 : presc + 1'b1;
        acc   <= acc_inc;
      end

      if (valid_n) dist_cm <= acc_inc;
    end
  end

endmodule

// File: tb/tb_hcsr04_ranger.sv
// Bench for hcsr04_ranger: a continuous and a one-shot instance checked every cycle
// against an event-level model (trigger windows, echo widths, timeout deadlines).
module tb_hcsr04_ranger;

  localparam int TRIG = 10;
  localparam int TMO  = 2500;
  localparam int PER  = 3000;
  localparam int CM   = 58;
  localparam int DW   = 5;
  localparam int DMAX = 31;
  localparam int MAXM = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic btn_c, enable_c, start_c, echo_c;
  logic trig_c, valid_c, timeout_c, busy_c;
  logic [DW-1:0] dist_c;
  logic btn_o, enable_o, start_o, echo_o;
  logic trig_o, valid_o, timeout_o, busy_o;
  logic [DW-1:0] dist_o;

  hcsr04_ranger #(.CLK_FREQ_HZ(1_000_000), .TIMEOUT_US(TMO), .PERIOD_MS(3),
                  .DIST_W(DW), .CONTINUOUS(1'b1)) u_cont (
    .clk(clk), .btnC(btn_c), .enable(enable_c), .start(start_c), .echo(echo_c),
    .trig(trig_c), .dist_cm(dist_c), .valid(valid_c), .timeout(timeout_c), .busy(busy_c));

  hcsr04_ranger #(.CLK_FREQ_HZ(1_000_000), .TIMEOUT_US(TMO), .PERIOD_MS(3),
                  .DIST_W(DW), .CONTINUOUS(1'b0)) u_one (
    .clk(clk), .btnC(btn_o), .enable(enable_o), .start(start_o), .echo(echo_o),
    .trig(trig_o), .dist_cm(dist_o), .valid(valid_o), .timeout(timeout_o), .busy(busy_o));

  int n_chk = 0;
  int n_pass = 0;
  int cyc = 0;
  logic rst_seen [2];

  // Model: one entry per expected trigger
  int m_n [2];
  int m_trig [2][MAXM];
  int m_end  [2][MAXM];
  int m_evt  [2][MAXM];
  bit m_isv  [2][MAXM];
  logic [DW-1:0] m_dist [2][MAXM];
  logic [DW-1:0] exp_dist [2];

  int rise_c [32];
  int fall_c [32];
  int tmo_c  [32];
  int nr_c = 0, nf_c = 0, nt_c = 0, nr_o = 0;
  logic prev_trig_c = 1'b0, prev_trig_o = 1'b0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    rst_seen[0] <= btn_c;
    rst_seen[1] <= btn_o;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
  endtask

  // Echo driven right after edge F+d is seen by the edge logic 2 cycles later and
  // the registered result lands one edge after that.
  task automatic plan(input int inst, input int t, input int d, input int w);
    int k = m_n[inst];
    int f = t + TRIG;
    m_trig[inst][k] = t;
    m_end[inst][k]  = t + PER - 1;
    if (d >= 0 && d + w + 3 <= TMO) begin
      m_evt[inst][k]  = f + d + w + 3;
      m_isv[inst][k]  = 1'b1;
      m_dist[inst][k] = (w / CM > DMAX) ? DW'(DMAX) : DW'(w / CM);
    end else begin
      m_evt[inst][k]  = f + TMO;
      m_isv[inst][k]  = 1'b0;
      m_dist[inst][k] = '0;
    end
    m_n[inst] = k + 1;
  endtask

  task automatic cmp_inst(input int inst, input string name, input logic t, input logic v,
                          input logic o, input logic b, input logic [DW-1:0] d);
    logic et, ev, eo, eb;
    et = 1'b0; ev = 1'b0; eo = 1'b0; eb = 1'b0;
    if (rst_seen[inst]) exp_dist[inst] = '0;
    else begin
      for (int k = 0; k < m_n[inst]; k++) begin
        if (cyc >= m_trig[inst][k] && cyc < m_end[inst][k]) begin
          eb = 1'b1;
          if (cyc < m_trig[inst][k] + TRIG) et = 1'b1;
        end
        if (cyc == m_evt[inst][k]) begin
          if (m_isv[inst][k]) begin
            ev = 1'b1;
            exp_dist[inst] = m_dist[inst][k];
          end else eo = 1'b1;
        end
      end
    end
    check(name, {23'b0, t, v, o, b, d}, {23'b0, et, ev, eo, eb, exp_dist[inst]});
  endtask

  always @(negedge clk) begin
    if (cyc >= 1) begin
      cmp_inst(0, "cont_outputs", trig_c, valid_c, timeout_c, busy_c, dist_c);
      cmp_inst(1, "oneshot_outputs", trig_o, valid_o, timeout_o, busy_o, dist_o);
      if (trig_c && !prev_trig_c && nr_c < 32) begin rise_c[nr_c] = cyc; nr_c++; end
      if (!trig_c && prev_trig_c && nf_c < 32) begin fall_c[nf_c] = cyc; nf_c++; end
      if (timeout_c && nt_c < 32) begin tmo_c[nt_c] = cyc; nt_c++; end
      if (trig_o && !prev_trig_o) nr_o++;
      prev_trig_c = trig_c;
      prev_trig_o = trig_o;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) step();
  endtask

  task automatic run_cont(input int t, input int d, input int w, input bit stuck, input int exp_d);
    int f = t + TRIG;
    plan(0, t, stuck ? -1 : d, w);
    if (stuck) begin
      wait_until(t - 20); echo_c = 1'b1;
      wait_until(f + 2560); echo_c = 1'b0;
    end else if (d >= 0) begin
      wait_until(f + d); echo_c = 1'b1;
      wait_until(f + d + w); echo_c = 1'b0;
    end
    wait_until(t + 2600);
    check("dist_after_measurement", 32'(dist_c), exp_d);
  endtask

  int tb_d [12]   = '{200,   50, 50,  50,  200, -1, 0, 10,   10,   200,  10,   10};
  int tb_w [12]   = '{1160,  57, 58,  115, 1160, 0, 0, 2000, 2550, 1160, 2487, 2488};
  bit tb_s [12]   = '{0,     0,  0,   0,   0,    0, 1, 0,    0,    0,    0,    0};
  int tb_exp [12] = '{20,    0,  1,   1,   20,  20, 20, 31,  31,   20,   31,   31};

  initial begin
    #(2_000_000);
    $display("FAIL watchdog: simulation did not finish by cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int rel, t1, s, f2, k2;
    btn_c = 1'b1; enable_c = 1'b1; start_c = 1'b0; echo_c = 1'b0;
    btn_o = 1'b1; enable_o = 1'b0; start_o = 1'b0; echo_o = 1'b0;
    m_n[0] = 0; m_n[1] = 0;
    exp_dist[0] = '0; exp_dist[1] = '0;

    // Reset held with echo toggling
    for (int i = 0; i < 5; i++) begin
      step();
      echo_c = ~echo_c;
    end
    echo_c = 1'b0;
    btn_c = 1'b0;
    rel = cyc;
    t1 = rel + 1;

    for (int k = 0; k < 12; k++) begin
      run_cont(t1 + k * PER, tb_d[k], tb_w[k], tb_s[k], tb_exp[k]);
    end
    enable_c = 1'b0;
    wait_until(t1 + 12 * PER + 500);

    check("first_trig_delay", rise_c[0] - rel, 1);
    check("trig_width", fall_c[0] - rise_c[0], TRIG);
    check("trig_period", rise_c[1] - rise_c[0], PER);
    check("timeout_after_trig_fall", tmo_c[0] - fall_c[5], TMO);
    check("cont_trigger_count", nr_c, 12);
    check("cont_timeout_count", nt_c, 4);

    // One-shot instance
    btn_o = 1'b0;
    step(); step(); step();
    s = cyc;
    plan(1, s + 1, 100, 580);
    start_o = 1'b1; step(); start_o = 1'b0;
    wait_until(s + 51); start_o = 1'b1; step(); start_o = 1'b0;
    wait_until(s + 1 + TRIG + 100); echo_o = 1'b1;
    wait_until(s + 1 + TRIG + 680); echo_o = 1'b0;
    wait_until(s + 1 + 1500); start_o = 1'b1; step(); start_o = 1'b0;
    wait_until(s + 1 + PER + 10);
    check("oneshot_dist", 32'(dist_o), 10);
    check("oneshot_idle", 32'(busy_o), 0);

    // Second request, aborted by reset mid-measurement
    s = cyc;
    k2 = m_n[1];
    plan(1, s + 1, 100, 1500);
    start_o = 1'b1; step(); start_o = 1'b0;
    f2 = s + 1 + TRIG;
    wait_until(f2 + 100); echo_o = 1'b1;
    wait_until(f2 + 600);
    m_end[1][k2] = f2 + 601;
    m_evt[1][k2] = -1;
    btn_o = 1'b1;
    step();
    check("abort_trig_busy", {30'b0, trig_o, busy_o}, 0);
    step();
    btn_o = 1'b0;
    wait_until(f2 + 1500); echo_o = 1'b0;
    wait_until(f2 + 3500);
    check("oneshot_trigger_count", nr_o, 2);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
